// File: rtl/clock_gate_ctrl_if.sv
// Handshake bundle between the clock-gating controller and its surroundings.
// The slave side is the controller; the master side drives activity/acks.
interface clock_gate_ctrl_if;
  logic       activity;
  logic       wake_req;
  logic       stop_ack;
  logic       stop_req;
  logic       enable;
  logic       clk_ready;
  logic [1:0] state;

  modport master (
    output activity, wake_req, stop_ack,
    input  stop_req, enable, clk_ready, state
  );

  modport slave (
    input  activity, wake_req, stop_ack,
    output stop_req, enable, clk_ready, state
  );
endinterface

// File: rtl/clock_gate_ctrl.sv
// Clock-gating controller: produces the enable for the gating cell.
// Watches downstream activity, requests a stop after an idle window, waits
// for the downstream ack, parks the clock, and restores it with a settle
// window on activity or an external wake. Lives in the always-on clk domain.
module clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  clock_gate_ctrl_if.slave  cg
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_REQ   = 2'd1,
    S_GATED = 2'd2,
    S_WAKE  = 2'd3
  } state_t;

  // Terminal counts: the transition fires on the edge that ends the last
  // counted cycle, so compare against N-1.
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] w_idle_cnt_nxt;
  logic [CNT_W-1:0] r_wake_cnt;
  logic [CNT_W-1:0] w_wake_cnt_nxt;
  logic             r_enable;
  logic             r_stop_req;
  logic             r_clk_ready;
  logic             w_wake;

  // External wake is treated exactly like downstream activity.
  assign w_wake = cg.activity | cg.wake_req;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Next-state and counter update; RUN entry always restarts the idle window.
  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    w_wake_cnt_nxt = r_wake_cnt;
    unique case (r_state)
      S_WAKE: begin
        // Settle window: inputs are ignored until the clock is known good.
        w_wake_cnt_nxt = sat_inc(r_wake_cnt);
        if (r_wake_cnt >= WAKE_LAST) begin
          w_state_nxt    = S_RUN;
          w_idle_cnt_nxt = '0;
        end
      end
      S_RUN: begin
        if (w_wake) begin
          w_idle_cnt_nxt = '0;
        end else begin
          w_idle_cnt_nxt = sat_inc(r_idle_cnt);
          if (r_idle_cnt >= IDLE_LAST) begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        // New work aborts the stop even if the ack lands in the same cycle.
        if (w_wake) begin
          w_state_nxt    = S_RUN;
          w_idle_cnt_nxt = '0;
        end else if (cg.stop_ack) begin
          w_state_nxt = S_GATED;
        end
      end
      S_GATED: begin
        if (w_wake) begin
          w_state_nxt    = S_WAKE;
          w_wake_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = S_WAKE;
        w_wake_cnt_nxt = '0;
      end
    endcase
  end

  // State and counters; reset lands in WAKE so the clock runs out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_WAKE;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_wake_cnt <= w_wake_cnt_nxt;
    end
  end

  // Outputs are flops decoded from the next state so enable is glitch-free
  // and tracks r_state cycle-for-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable    <= 1'b1;
      r_stop_req  <= 1'b0;
      r_clk_ready <= 1'b0;
    end else begin
      r_enable    <= (w_state_nxt != S_GATED);
      r_stop_req  <= (w_state_nxt == S_REQ) || (w_state_nxt == S_GATED);
      r_clk_ready <= (w_state_nxt == S_RUN) || (w_state_nxt == S_REQ);
    end
  end

  assign cg.enable    = r_enable;
  assign cg.stop_req  = r_stop_req;
  assign cg.clk_ready = r_clk_ready;
  assign cg.state     = r_state;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl: directed test-plan scenarios with
// literal expectations, then randomized traffic against a timestamp model.
module tb_clock_gate_ctrl;
  localparam int IDLE_CYCLES = 16;
  localparam int WAKE_CYCLES = 2;
  localparam int CNT_W       = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;

  clock_gate_ctrl_if cg();

  clock_gate_ctrl #(
    .IDLE_CYCLES(IDLE_CYCLES),
    .WAKE_CYCLES(WAKE_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cg   (cg)
  );

  always #5 clk = ~clk;

  // Reference model: mode plus edge timestamps. RUN stops once IDLE_CYCLES
  // edges have passed since the later of RUN entry and the last wake sample;
  // WAKE ends WAKE_CYCLES edges after it was entered.
  int m_mode      = 3;  // 0 RUN, 1 REQ, 2 GATED, 3 WAKE
  int n_edge      = 0;
  int m_enter     = 0;
  int m_last_wake = 0;
  bit m_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 3; n_edge = 0; m_enter = 0; m_last_wake = 0;
    end else begin
      m_w = cg.activity | cg.wake_req;
      n_edge++;
      case (m_mode)
        3: if (n_edge - m_enter == WAKE_CYCLES) begin
             m_mode = 0; m_last_wake = n_edge;
           end
        0: if (m_w) m_last_wake = n_edge;
           else if (n_edge - m_last_wake == IDLE_CYCLES) m_mode = 1;
        1: if (m_w) begin m_mode = 0; m_last_wake = n_edge; end
           else if (cg.stop_ack) m_mode = 2;
        default: if (m_w) begin m_mode = 3; m_enter = n_edge; end
      endcase
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic       e_en, e_sr, e_rdy;
      logic [1:0] e_st;
      e_en  = (m_mode != 2);
      e_sr  = (m_mode == 1) || (m_mode == 2);
      e_rdy = (m_mode <= 1);
      e_st  = 2'(m_mode);
      checks += 4;
      if (cg.enable !== e_en) begin
        failures++;
        $display("FAIL model_enable t=%0t got=%b exp=%b", $time, cg.enable, e_en);
      end
      if (cg.stop_req !== e_sr) begin
        failures++;
        $display("FAIL model_stop_req t=%0t got=%b exp=%b", $time, cg.stop_req, e_sr);
      end
      if (cg.clk_ready !== e_rdy) begin
        failures++;
        $display("FAIL model_clk_ready t=%0t got=%b exp=%b", $time, cg.clk_ready, e_rdy);
      end
      if (cg.state !== e_st) begin
        failures++;
        $display("FAIL model_state t=%0t got=%0d exp=%0d", $time, cg.state, e_st);
      end
    end
  end

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int phase_left;
    bit quiet;
    cg.activity = 1'b1;
    cg.wake_req = 1'b0;
    cg.stop_ack = 1'b0;
    rst_n       = 1'b1;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;

    // Reset release
    step(2);
    chk("rst_enable", {1'b0, cg.enable}, 2'd1);
    chk("rst_clk_ready", {1'b0, cg.clk_ready}, 2'd0);
    chk("rst_state", cg.state, 2'd3);
    rst_n = 1'b1;
    step(1);
    chk("rel_edge1_ready", {1'b0, cg.clk_ready}, 2'd0);
    step(1);
    chk("rel_edge2_ready", {1'b0, cg.clk_ready}, 2'd1);
    chk("rel_edge2_state", cg.state, 2'd0);

    // Full gate cycle
    step(2);
    cg.activity = 1'b0;
    step(15);
    chk("idle15_stop_req", {1'b0, cg.stop_req}, 2'd0);
    step(1);
    chk("idle16_stop_req", {1'b0, cg.stop_req}, 2'd1);
    chk("idle16_state", cg.state, 2'd1);
    cg.stop_ack = 1'b1;
    step(1);
    cg.stop_ack = 1'b0;
    chk("ack_enable", {1'b0, cg.enable}, 2'd0);
    chk("ack_state", cg.state, 2'd2);
    step(3);
    chk("gated_hold_state", cg.state, 2'd2);

    // Wake from GATED, ack during WAKE ignored
    cg.wake_req = 1'b1;
    step(1);
    cg.wake_req = 1'b0;
    cg.stop_ack = 1'b1;
    chk("wake_enable", {1'b0, cg.enable}, 2'd1);
    chk("wake_stop_req", {1'b0, cg.stop_req}, 2'd0);
    chk("wake_state", cg.state, 2'd3);
    step(1);
    chk("wake_e1_ready", {1'b0, cg.clk_ready}, 2'd0);
    step(1);
    cg.stop_ack = 1'b0;
    chk("wake_e2_ready", {1'b0, cg.clk_ready}, 2'd1);
    chk("wake_e2_state", cg.state, 2'd0);

    // Idle counter restart
    cg.activity = 1'b1;
    step(1);
    cg.activity = 1'b0;
    step(15);
    cg.activity = 1'b1;
    step(1);
    cg.activity = 1'b0;
    step(1);
    chk("restart_no_early_req", {1'b0, cg.stop_req}, 2'd0);
    step(14);
    chk("restart_15_stop_req", {1'b0, cg.stop_req}, 2'd0);
    step(1);
    chk("restart_16_stop_req", {1'b0, cg.stop_req}, 2'd1);

    // Abort precedence over ack
    cg.activity = 1'b1;
    cg.stop_ack = 1'b1;
    step(1);
    cg.stop_ack = 1'b0;
    chk("abort_state", cg.state, 2'd0);
    chk("abort_stop_req", {1'b0, cg.stop_req}, 2'd0);
    chk("abort_enable", {1'b0, cg.enable}, 2'd1);

    // Reset mid-operation from GATED
    cg.activity = 1'b0;
    step(16);
    cg.stop_ack = 1'b1;
    step(1);
    cg.stop_ack = 1'b0;
    chk("pre_rst_state", cg.state, 2'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_enable", {1'b0, cg.enable}, 2'd1);
    chk("async_rst_stop_req", {1'b0, cg.stop_req}, 2'd0);
    chk("async_rst_state", cg.state, 2'd3);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_ready", {1'b0, cg.clk_ready}, 2'd1);

    // Randomized traffic: alternating busy and quiet phases, random acks,
    // rare wake requests and rare mid-cycle resets.
    phase_left = 0;
    quiet      = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (phase_left == 0) begin
        quiet      = ($urandom_range(2) != 0);
        phase_left = $urandom_range(80, 20);
      end
      phase_left--;
      cg.activity = quiet ? ($urandom_range(99) < 2) : ($urandom_range(1) == 1);
      cg.wake_req = ($urandom_range(199) == 0);
      cg.stop_ack = ($urandom_range(99) < 30);
      if ($urandom_range(799) == 0) begin
        #2 rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end else begin
        step(1);
      end
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
